// File: rtl/bram_burst_reader.sv
// Burst read initiator for a single-port bram with 1-cycle registered read latency.
// Issues reads on demand into a 2-entry output FIFO and streams words out on valid/ready with last.
module bram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [ADDR_WIDTH-1:0] req_len_i,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    input  logic [DATA_WIDTH-1:0] bram_data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  busy_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH:0]    issue_q;
    logic [ADDR_WIDTH:0]    beat_q;
    logic                   inflight_q;
    logic [1:0]             count_q;
    logic [1:0]             count_d;
    logic                   rd_ptr_q;
    logic                   wr_ptr_q;
    logic [DATA_WIDTH-1:0]  fifo_q [2];

    logic                   req_fire;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occupancy;
    logic [2:0]             limit;

    // A read may be issued only if the word it returns is guaranteed a FIFO slot,
    // counting the read still in flight and any pop happening this cycle.
    always_comb begin
        req_fire  = req_valid_i & (state_q == S_IDLE);
        pop       = (count_q != 2'd0) & ready_i;
        push      = inflight_q;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        limit     = 3'd2 + {2'b00, pop};
        issue     = (state_q == S_RUN) && (issue_q != '0) && (occupancy < limit);
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign bram_en_o   = issue;
    assign bram_addr_o = addr_q;
    assign bram_we_o   = 1'b0;
    assign bram_data_o = '0;
    assign valid_o     = (count_q != 2'd0);
    assign data_o      = fifo_q[rd_ptr_q];
    assign last_o      = valid_o & (beat_q == CNT_ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            issue_q <= '0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        addr_q  <= req_addr_i;
                        issue_q <= {1'b0, req_len_i} + CNT_ONE;
                        beat_q  <= {1'b0, req_len_i} + CNT_ONE;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr_q  <= addr_q + ADDR_ONE;
                        issue_q <= issue_q - CNT_ONE;
                    end
                    if (pop) begin
                        beat_q <= beat_q - CNT_ONE;
                        if (last_o) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output FIFO: bram data is captured the cycle after its read was issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            inflight_q <= issue;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= bram_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: bram model plus expected-beat queues built from the memory image.
// Directed bursts (single, stream, backpressure, wrap, abort) followed by random bursts.
module tb_bram_burst_reader;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [AW-1:0] req_len_i = '0;
    logic          bram_en_o;
    logic          bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_data_o;
    logic [DW-1:0] bram_data_i;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          busy_o;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] bram_rdata = '0;

    int n_checks = 0;
    int n_fails  = 0;

    bram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .bram_en_o   (bram_en_o),
        .bram_we_o   (bram_we_o),
        .bram_addr_o (bram_addr_o),
        .bram_data_o (bram_data_o),
        .bram_data_i (bram_data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Single-port bram with registered read.
    always @(posedge clk_i) begin
        if (bram_en_o) bram_rdata <= mem[bram_addr_o];
    end
    assign bram_data_i = bram_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_bram_en"}, bram_en_o, 0);
        chk({tag, "_bram_addr"}, bram_addr_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_last"}, last_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_we_wdata"}, {bram_we_o, bram_data_o}, 0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 (or at a negedge if aborted).
    task automatic run_burst(input int a, input int l, input bit rand_ready, input int abort_after);
        logic [DW-1:0] exp_data [$];
        int            exp_addr [$];
        int            n, beats, issued, cyc, first_valid;
        bit            stall, fire, aborted;
        logic [DW-1:0] held_data;
        logic          held_last;
        n = l + 1;
        beats = 0; issued = 0; cyc = 0; first_valid = -1;
        stall = 0; aborted = 0; held_data = '0; held_last = 0;
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(mem[(a + i) % DEPTH]);
            exp_addr.push_back((a + i) % DEPTH);
        end
        req_valid_i = 1'b1;
        req_addr_i  = AW'(a);
        req_len_i   = AW'(l);
        ready_i     = 1'b1;
        @(negedge clk_i);
        chk("req_ready_idle", req_ready_o, 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        while (beats < n && cyc < 500) begin
            if (rand_ready) begin
                ready_i     = 1'($urandom_range(0, 1));
                req_valid_i = 1'($urandom_range(0, 1));
                req_addr_i  = AW'($urandom_range(0, DEPTH - 1));
                req_len_i   = AW'($urandom_range(0, DEPTH - 1));
            end else begin
                ready_i = 1'b1;
            end
            @(negedge clk_i);
            chk("busy_in_run", busy_o, 1);
            chk("we_wdata_const", {bram_we_o, bram_data_o}, 0);
            if (bram_en_o) begin
                if (issued < n) chk("bram_addr", bram_addr_o, exp_addr[issued]);
                issued++;
                chk("issue_le_len", issued <= n, 1);
            end
            if (stall) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_data", data_o, held_data);
                chk("stall_last", last_o, held_last);
            end
            fire = valid_o & ready_i;
            if (valid_o && first_valid < 0) first_valid = cyc;
            chk("outstanding_le2", (issued - beats - int'(fire)) <= 2, 1);
            if (fire) begin
                chk("beat_data", data_o, exp_data[beats]);
                chk("beat_last", last_o, beats == n - 1);
                beats++;
            end
            stall     = valid_o & ~ready_i;
            held_data = data_o;
            held_last = last_o;
            if (abort_after > 0 && beats == abort_after) begin
                aborted = 1;
                break;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        req_valid_i = 1'b0;
        if (!aborted) begin
            chk("burst_complete", beats, n);
            chk("issued_total", issued, n);
            chk("first_valid_latency", first_valid, 2);
            if (!rand_ready) chk("stream_cycles", cyc, n + 2);
            @(negedge clk_i);
            chk("req_ready_after", req_ready_o, 1);
            chk("busy_after", busy_o, 0);
            chk("valid_after", valid_o, 0);
            @(posedge clk_i); #1;
        end
        $display("burst addr=%0d len=%0d rand_ready=%0d beats=%0d issued=%0d cycles=%0d",
                 a, l, rand_ready, beats, issued, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        rst_i = 1'b1;
        #2;
        check_reset_state("rst_init");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        mem[7] = 32'hA5A5_0007;
        run_burst(7, 0, 0, 0);
        mem[7] = 32'd7;

        run_burst(3, 3, 0, 0);
        run_burst(0, 7, 1, 0);
        run_burst(30, 3, 0, 0);
        run_burst(30, 3, 1, 0);

        // Abort mid-burst with an asynchronous reset between clock edges.
        run_burst(0, 7, 0, 2);
        @(posedge clk_i); #1;
        chk("valid_before_abort", valid_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_state("rst_abort");
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        run_burst(10, 0, 0, 0);

        run_burst(5, 31, 0, 0);
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            run_burst($urandom_range(0, DEPTH - 1),
                      (k == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1), 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
